// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and memory sizing for the slave and its byte RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 8;
    localparam int STRB_WIDTH  = 1;
    localparam int BUFFER_SIZE = 4096;
    localparam int MEM_AW      = $clog2(BUFFER_SIZE);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } state_type;

endpackage

// File: rtl/axi_lite_slv_mem.sv
// Single-port synchronous byte RAM backing the AXI4-Lite slave; contents are never reset.
// Latency: write commits at the clock edge; read data is registered one edge after re.
// Backpressure: none; rdat holds its value while re is low.
module axi_lite_slv_mem
    import axi_lite_pkg::*;
#(
    parameter int MEM_BYTES = BUFFER_SIZE,
    parameter int AW        = MEM_AW
) (
    input  logic          aclk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  data_t         wdat,
    output data_t         rdat
);

    data_t mem [MEM_BYTES];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
        if (re) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave with one decoded byte-memory window; out-of-window accesses get DECERR. Option: AXI_LITE_SLV_WAIT_EN.
// Latency: rvalid 2 cycles after AR handshake, bvalid 2 cycles after W handshake (+WAIT_CYCLES with AXI_LITE_SLV_WAIT_EN).
// Backpressure: one transaction at a time; R/B held stable until rready/bready, no new AR/AW accepted meanwhile.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter addr_t BASE_ADDR   = 32'h0,
    parameter int    MEM_BYTES   = BUFFER_SIZE,
    parameter int    WAIT_CYCLES = 2
) (
    input  logic  aclk,
    input  logic  areset,
    input  addr_t araddr,
    input  logic  arvalid,
    output logic  arready,
    output data_t rdata,
    output resp_t rresp,
    output logic  rvalid,
    input  logic  rready,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  strb_t wstrb,
    input  logic  wvalid,
    output logic  wready,
    output resp_t bresp,
    output logic  bvalid,
    input  logic  bready
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    if (((MEM_BYTES & (MEM_BYTES - 1)) != 0) ||
        ((BASE_ADDR & addr_t'(MEM_BYTES - 1)) != '0) ||
        (WAIT_CYCLES < 0)) begin : g_bad_cfg
        $error("axi_lite_mem_slave: MEM_BYTES must be a power of 2, BASE_ADDR aligned, WAIT_CYCLES >= 0");
    end

    state_type        state;
    state_type        state_nxt;
    addr_t            addr_q;
    data_t            wdata_q;
    strb_t            wstrb_q;
    addr_t            off;
    logic             in_range;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;
    logic             mem_re;
    data_t            mem_rdat;
    logic             phase_last;

    // Unsigned wrap of the subtraction makes addresses below BASE_ADDR fall out of range too.
    assign off      = addr_q - BASE_ADDR;
    assign in_range = (off < addr_t'(MEM_BYTES));
    assign mem_idx  = off[IDX_W-1:0];

`ifdef AXI_LITE_SLV_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wait_cnt <= '0;
        end else if ((state == IDLE && arvalid) || (state == WADDR && wvalid)) begin
            wait_cnt <= CNT_W'(WAIT_CYCLES);
        end else if ((state == RADDR || state == WDATA) && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    assign phase_last = (wait_cnt == '0);
`else
    assign phase_last = 1'b1;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (arvalid) begin
                    state_nxt = RADDR;
                end else if (awvalid) begin
                    state_nxt = WADDR;
                end
            end
            RADDR:   if (phase_last) state_nxt = RDATA;
            RDATA:   if (rready)     state_nxt = IDLE;
            WADDR:   if (wvalid)     state_nxt = WDATA;
            WDATA:   if (phase_last) state_nxt = WRESP;
            WRESP:   if (bready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are gated by areset so every handshake output is low while reset is held.
    always_comb begin
        arready = (state == IDLE) && !areset;
        awready = (state == IDLE) && !arvalid && !areset;
        wready  = (state == WADDR);
        rvalid  = (state == RDATA);
        bvalid  = (state == WRESP);
        rdata   = (state == RDATA && in_range) ? mem_rdat : '0;
        rresp   = (state == RDATA && !in_range) ? RESP_DECERR : RESP_OKAY;
        bresp   = (state == WRESP && !in_range) ? RESP_DECERR : RESP_OKAY;
        mem_re  = (state == RADDR) && phase_last;
        mem_we  = (state == WDATA) && phase_last && in_range && wstrb_q[0];
    end

    // Address is frozen from its handshake until the response completes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (state == IDLE) begin
                if (arvalid) begin
                    addr_q <= araddr;
                end else if (awvalid) begin
                    addr_q <= awaddr;
                end
            end
            if (state == WADDR && wvalid) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    axi_lite_slv_mem #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (IDX_W)
    ) u_mem (
        .aclk (aclk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_idx),
        .wdat (wdata_q),
        .rdat (mem_rdat)
    );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave against an array model of the decoded window.
module tb_axi_lite_mem_slave;
    import axi_lite_pkg::*;

    localparam addr_t TB_BASE = 32'h0;
    localparam int    TB_MEM  = 4096;
    localparam int    TB_WAIT = 2;
    localparam int    TMO     = 40;
`ifdef AXI_LITE_SLV_WAIT_EN
    localparam int    EXP_LAT = 2 + TB_WAIT;
`else
    localparam int    EXP_LAT = 2;
`endif

    logic  aclk = 1'b0;
    logic  areset;
    addr_t araddr, awaddr;
    logic  arvalid, arready, rvalid, rready;
    logic  awvalid, awready, wvalid, wready, bvalid, bready;
    data_t rdata, wdata;
    strb_t wstrb;
    resp_t rresp, bresp;

    int checks = 0;
    int errors = 0;

    data_t model_mem   [TB_MEM];
    bit    model_known [TB_MEM];

    always #5 aclk = ~aclk;

    axi_lite_mem_slave #(
        .BASE_ADDR   (TB_BASE),
        .MEM_BYTES   (TB_MEM),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    function automatic bit in_win(input addr_t a);
        addr_t off;
        off = a - TB_BASE;
        return off < addr_t'(TB_MEM);
    endfunction

    function automatic int midx(input addr_t a);
        addr_t off;
        off = a - TB_BASE;
        return int'(off % TB_MEM);
    endfunction

    function automatic resp_t exp_resp(input addr_t a);
        return in_win(a) ? RESP_OKAY : RESP_DECERR;
    endfunction

    function automatic void model_write(input addr_t a, input data_t d, input strb_t s);
        if (in_win(a) && s[0]) begin
            model_mem[midx(a)]   = d;
            model_known[midx(a)] = 1'b1;
        end
    endfunction

    // Transactions start and end #1 after a rising edge; outputs are sampled on falling edges.
    task automatic axi_read(input addr_t a, input int stall, output data_t d, output resp_t r,
                            output int lat, output bit stable);
        int n;
        stable  = 1'b1;
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < TMO) begin n++; @(negedge aclk); end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready=%0b required 1", arready);
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        lat = 1;
        @(negedge aclk);
        while (!rvalid && lat < TMO) begin lat++; @(negedge aclk); end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL r_timeout: rvalid=%0b required 1", rvalid);
        end
        d = rdata;
        r = rresp;
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk); @(negedge aclk);
            if (!rvalid || rdata !== d || rresp !== r) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input addr_t a, input data_t d, input strb_t s, input int stall,
                             output resp_t r, output int lat, output bit stable);
        int n;
        stable  = 1'b1;
        awaddr  = a;
        awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < TMO) begin n++; @(negedge aclk); end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        awaddr  = $urandom;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!wready && n < TMO) begin n++; @(negedge aclk); end
        if (!wready) begin
            checks++; errors++;
            $display("FAIL w_timeout: wready=%0b required 1", wready);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0;
        wdata  = $urandom;
        lat = 1;
        @(negedge aclk);
        while (!bvalid && lat < TMO) begin lat++; @(negedge aclk); end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
        end
        r = bresp;
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk); @(negedge aclk);
            if (!bvalid || bresp !== r) stable = 1'b0;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ar/aw/w/r/b=%b required 00000",
                     {arready, awready, wready, rvalid, bvalid});
        end
        checks++;
        if (rdata !== 8'h00 || rresp !== RESP_OKAY || bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL reset_data: rdata=%h rresp=%0d bresp=%0d required 00/0/0", rdata, rresp, bresp);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: arready=%b awready=%b required 1/1", arready, awready);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        data_t d; resp_t r; int lat; bit st;
        axi_write(32'h4, 8'hA5, 1'b1, 0, r, lat, st);
        model_write(32'h4, 8'hA5, 1'b1);
        checks++;
        if (r !== RESP_OKAY || lat != EXP_LAT) begin
            errors++;
            $display("FAIL basic_write: bresp=%0d lat=%0d required 0/%0d", r, lat, EXP_LAT);
        end
        axi_read(32'h4, 0, d, r, lat, st);
        checks++;
        if (d !== 8'hA5 || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL basic_read: rdata=%h rresp=%0d required a5/0", d, r);
        end
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL read_latency: got %0d required %0d", lat, EXP_LAT);
        end
    endtask

    task automatic test_strb0();
        data_t d; resp_t r; int lat; bit st;
        axi_write(32'h14, 8'h77, 1'b1, 0, r, lat, st);
        model_write(32'h14, 8'h77, 1'b1);
        axi_write(32'h14, 8'h3C, 1'b0, 0, r, lat, st);
        model_write(32'h14, 8'h3C, 1'b0);
        checks++;
        if (r !== RESP_OKAY) begin
            errors++;
            $display("FAIL strb0_bresp: got %0d required %0d", r, RESP_OKAY);
        end
        axi_read(32'h14, 0, d, r, lat, st);
        checks++;
        if (d !== model_mem[midx(32'h14)] || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL strb0_read: rdata=%h rresp=%0d required %h/0", d, r, model_mem[midx(32'h14)]);
        end
    endtask

    task automatic test_decode();
        data_t d; resp_t r; int lat; bit st;
        axi_write(32'h0, 8'h11, 1'b1, 0, r, lat, st);
        model_write(32'h0, 8'h11, 1'b1);
        axi_read(32'h1000, 0, d, r, lat, st);
        checks++;
        if (d !== 8'h00 || r !== RESP_DECERR) begin
            errors++;
            $display("FAIL decerr_read: rdata=%h rresp=%0d required 00/3", d, r);
        end
        axi_write(32'h1000, 8'hEE, 1'b1, 0, r, lat, st);
        checks++;
        if (r !== RESP_DECERR) begin
            errors++;
            $display("FAIL decerr_write: bresp=%0d required 3", r);
        end
        axi_read(32'h0, 0, d, r, lat, st);
        checks++;
        if (d !== model_mem[0] || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL no_alias: rdata=%h rresp=%0d required %h/0", d, r, model_mem[0]);
        end
        axi_write(32'hFFF, 8'h99, 1'b1, 0, r, lat, st);
        model_write(32'hFFF, 8'h99, 1'b1);
        axi_read(32'hFFF, 0, d, r, lat, st);
        checks++;
        if (d !== 8'h99 || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL last_loc: rdata=%h rresp=%0d required 99/0", d, r);
        end
        axi_read(32'hFFFF_FFFF, 0, d, r, lat, st);
        checks++;
        if (r !== exp_resp(32'hFFFF_FFFF) || d !== 8'h00) begin
            errors++;
            $display("FAIL high_addr: rdata=%h rresp=%0d required 00/3", d, r);
        end
    endtask

    task automatic test_collision();
        int n; int viol;
        araddr  = 32'h4;  arvalid = 1'b1;
        awaddr  = 32'h14; awvalid = 1'b1;
        wdata   = 8'h5A;  wstrb = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            errors++;
            $display("FAIL collide_ready: arready=%b awready=%b required 1/0", arready, awready);
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        viol = 0; n = 0;
        @(negedge aclk);
        while (!rvalid && n < TMO) begin
            if (awready || wready) viol++;
            n++;
            @(negedge aclk);
        end
        if (awready || wready) viol++;
        checks++;
        if (!rvalid || rdata !== model_mem[midx(32'h4)]) begin
            errors++;
            $display("FAIL collide_read: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, model_mem[midx(32'h4)]);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        if (wready) viol++;
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL collide_aw: awready=%b required 1", awready);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL early_ready: %0d cycles with awready/wready high, required 0", viol);
        end
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL collide_w: wready=%b required 1", wready);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0;
        model_write(32'h14, 8'h5A, 1'b1);
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < TMO) begin n++; @(negedge aclk); end
        checks++;
        if (!bvalid || bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL collide_b: bvalid=%b bresp=%0d required 1/0", bvalid, bresp);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic test_backpressure();
        data_t d; resp_t r; int lat; bit st;
        axi_read(32'h4, 5, d, r, lat, st);
        checks++;
        if (!st || d !== model_mem[midx(32'h4)] || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL r_stall: stable=%b rdata=%h required 1/%h", st, d, model_mem[midx(32'h4)]);
        end
        axi_write(32'h1234, 8'h42, 1'b1, 5, r, lat, st);
        checks++;
        if (!st || r !== exp_resp(32'h1234)) begin
            errors++;
            $display("FAIL b_stall: stable=%b bresp=%0d required 1/%0d", st, r, exp_resp(32'h1234));
        end
    endtask

    task automatic test_reset_mid();
        data_t d; resp_t r; int lat; bit st; int n;
        awaddr = 32'h4; awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < TMO) begin n++; @(negedge aclk); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wdata   = 8'hDE;
        wstrb   = 1'b1;
        areset  = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({wready, rvalid, bvalid} !== 3'b0 || rdata !== 8'h00 || arready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: w/r/b=%b rdata=%h arready=%b required 000/00/1",
                     {wready, rvalid, bvalid}, rdata, arready);
        end
        @(posedge aclk); #1;
        axi_read(32'h4, 0, d, r, lat, st);
        checks++;
        if (d !== model_mem[midx(32'h4)] || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL mid_reset_read: rdata=%h required %h", d, model_mem[midx(32'h4)]);
        end
    endtask

    task automatic test_back_to_back();
        int hs[$]; int cyc; int bad; int n;
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b1;
        cyc = 0; bad = 0;
        while (hs.size() < 4 && cyc < 60) begin
            @(negedge aclk);
            if (arready) hs.push_back(cyc);
            if (rvalid && rdata !== model_mem[midx(32'h4)]) bad++;
            @(posedge aclk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!rvalid && n < TMO) begin n++; @(negedge aclk); end
        @(posedge aclk); #1;
        rready = 1'b0;
        checks++;
        if (hs.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL b2b_count: handshakes=%0d bad_data=%0d required 4/0", hs.size(), bad);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (hs[i] - hs[i-1] != EXP_LAT + 1) begin
                    errors++;
                    $display("FAIL b2b_gap: %0d cycles required %0d", hs[i] - hs[i-1], EXP_LAT + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        addr_t pool[8]; addr_t a; data_t d; strb_t s; resp_t r; int lat; bit st; int sel; int stall;
        for (int i = 0; i < 8; i++) pool[i] = TB_BASE + addr_t'($urandom_range(0, TB_MEM - 1));
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = pool[$urandom_range(0, 7)];
            else if (sel == 7) a = TB_BASE + addr_t'(TB_MEM) + addr_t'($urandom_range(0, 16'hFFFF));
            else if (sel == 8) a = $urandom | 32'h8000_0000;
            else               a = TB_BASE + addr_t'(TB_MEM - 1);
            stall = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = $urandom;
                axi_write(a, d, s, stall, r, lat, st);
                model_write(a, d, s);
                checks++;
                if (r !== exp_resp(a) || lat != EXP_LAT || !st) begin
                    errors++;
                    $display("FAIL rand_write @%h: bresp=%0d lat=%0d stable=%b required %0d/%0d/1",
                             a, r, lat, st, exp_resp(a), EXP_LAT);
                end
            end else begin
                axi_read(a, stall, d, r, lat, st);
                checks++;
                if (r !== exp_resp(a) || lat != EXP_LAT || !st ||
                    (!in_win(a) && d !== 8'h00) ||
                    (in_win(a) && model_known[midx(a)] && d !== model_mem[midx(a)])) begin
                    errors++;
                    $display("FAIL rand_read @%h: rdata=%h rresp=%0d lat=%0d stable=%b required %h/%0d/%0d/1",
                             a, d, r, lat, st, in_win(a) ? model_mem[midx(a)] : 8'h00, exp_resp(a), EXP_LAT);
                end
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < TB_MEM; i++) model_known[i] = 1'b0;
        test_reset();
        test_basic();
        test_strb0();
        test_decode();
        test_collision();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
AXI4-Lite responder (slave end) backed by a BUFFER_SIZE-byte internal memory. It answers read and write transactions from an AXI4-Lite master or interconnect port and decodes a single address window. Accesses outside the window complete with RESP_DECERR. One transaction is serviced at a time: read or write, never both.

Parameters:
BASE_ADDR, 32'h0, byte address of the first memory location (must be BUFFER_SIZE-aligned)
MEM_BYTES, BUFFER_SIZE (4096), depth of the byte memory (power of 2)
WAIT_CYCLES, 2, extra latency cycles in RADDR/WDATA; used only when AXI_LITE_SLV_WAIT_EN is defined

Ports:
aclk  input  1  clock, all logic on rising edge
areset  input  1  synchronous, active-high reset
araddr  input  ADDR_WIDTH(32)  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DATA_WIDTH(8)  read data
rresp  output  2  read response (resp_t)
rvalid  output  1  read data valid
rready  input  1  read data ready
awaddr  input  32  write address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  8  write data
wstrb  input  STRB_WIDTH(1)  write strobe
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready

Behaviour:
- Reset: state=IDLE; arready=awready=wready=rvalid=bvalid=0; rdata=0; rresp=bresp=RESP_OKAY. Memory contents are not cleared. Reset asserted mid-transaction aborts it: valids drop the next cycle and uncommitted writes are lost.
- FSM uses state_type:
  - IDLE: arready=1. awready=(!arvalid).
    - arvalid: latch araddr, go to RADDR.
    - else awvalid: latch awaddr, go to WADDR.
    - Read wins when both arrive in the same cycle; AW stays pending.
  - RADDR: one cycle. Decode the address and read memory. Go to RDATA.
  - RDATA: rvalid=1, rdata and rresp held stable until rready. On the rready handshake, return to IDLE.
    - Earliest rvalid is 2 cycles after the AR handshake.
  - WADDR: wready=1. On the W handshake, latch wdata/wstrb and go to WDATA.
    - W is never accepted before AW. wready=0 in all other states.
  - WDATA: one cycle.
    - Commit the write to memory if the address is in range and wstrb[0]=1.
    - Go to WRESP.
  - WRESP: bvalid=1, bresp stable until bready. On the handshake, return to IDLE.
- Decode:
  - off = addr - BASE_ADDR, computed modulo 2^32.
  - In range iff off < MEM_BYTES. Index = off[$clog2(MEM_BYTES)-1:0].
- Response:
  - In range: RESP_OKAY.
  - Out of range: RESP_DECERR. rdata=0 and no memory write.
  - wstrb=0 in range: no write, RESP_OKAY.
- Ready signals in IDLE are combinational from state and arvalid only; they never depend on rready/bready.
- Back-to-back: the IDLE cycle is mandatory between transactions. Throughput is one read per 3 cycles minimum, assuming rready is already high.
- Last location (off = MEM_BYTES-1) is in range; off = MEM_BYTES is DECERR. There is no wrap-around into memory.
- The latched address is frozen from handshake until the response handshake; changes on araddr/awaddr are ignored.

Optional Feature:
AXI_LITE_SLV_WAIT_EN:
- Defined: a down-counter (width $clog2(WAIT_CYCLES+1)) holds RADDR and WDATA for 1+WAIT_CYCLES cycles.
  - Read data is sampled on the last RADDR cycle.
  - The write is committed on the last WDATA cycle.
  - rvalid comes 2+WAIT_CYCLES cycles after AR; bvalid comes 2+WAIT_CYCLES cycles after W.
  - Reset clears the counter.
- Undefined: no counter logic. RADDR and WDATA each last exactly one cycle and WAIT_CYCLES is ignored.

Decomposition:
- Shared package (axi_lite_pkg) supplies the existing types and constants: addr_t, data_t, strb_t, resp_t, state_type, RESP_*, BUFFER_SIZE, ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH.
- Add to the package: localparam MEM_AW = $clog2(BUFFER_SIZE).
- One sub-module: axi_lite_slv_mem, a single-port synchronous byte RAM (MEM_BYTES x DATA_WIDTH, write enable, registered read). Instantiated once.

Test Plan:
- Write 0x4 data 0xA5 strb 1, then read 0x4 -> bresp=OKAY; rdata=0xA5, rresp=OKAY; rvalid exactly 2 cycles after AR handshake (feature off).
- Write 0x14 data 0x3C strb 0, then read 0x14 -> bresp=OKAY; rdata equals the value held before the write.
- Read 0x1000 and write 0x1000 (BASE 0, MEM_BYTES 4096) -> rresp=DECERR with rdata=0x00; bresp=DECERR; read of 0xFFF returns OKAY.
- arvalid and awvalid both asserted in the same cycle -> AR accepted first (arready=1, awready=0). AW is accepted in the IDLE after the rready handshake; wready is never high before the AW handshake.
- Hold rready=0 for 5 cycles with rvalid high -> rvalid, rdata and rresp stable all 5 cycles. Same check for bvalid with bready=0.
- Assert areset in WADDR after AW to 0x4, then read 0x4 -> all outputs 0 the cycle after reset; the read returns the pre-write value. With AXI_LITE_SLV_WAIT_EN and WAIT_CYCLES=2: rvalid comes 4 cycles after AR.
